// File: rtl/if_fetch_slice_pkg.sv
// Shared types and constants for the instruction-fetch slice.
// Holds the FLUSH bubble encoding, the default reset PC and the fetch-queue entry layout.
package if_pkg;

    // FLUSH bubble: opcode F with all operand fields zero
    localparam logic [15:0] NOP_INSTR        = 16'hF000;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // One fetched word plus the address of the word that follows it
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_inc;
    } fq_entry_t;

endpackage

// File: rtl/if_fetch_slice_fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetched words for the fetch slice.
// DEPTH must be a power of two so the read/write pointers wrap on their own.
// flush empties the queue and dominates push/pop in the same cycle.
module fetch_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fq_entry_t     din,
    input  logic          pop,
    input  logic          flush,
    output fq_entry_t     dout,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    fq_entry_t     mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush returns the queue to empty
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents are only meaningful where count says so
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; occupancy is tracked by count, so stale data is never read.
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/if_fetch_slice.sv
// if_fetch_slice: instruction-fetch stage feeding the IF/ID register.
// Issues in-order word fetches from fpc, tags responses with rpc + 1, buffers them in
// fetch_fifo and presents {instr, PC_inc, if_valid} to decode. Outstanding requests plus
// queued words never exceed FQ_DEPTH, so the queue cannot overflow.
// Optional macro IF_BYPASS_EN: a live response that finds the queue empty while the output
// register advances is loaded straight into the output register (one cycle less latency).
module if_fetch_slice
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] PC_inc,
    output logic        if_valid
);

    localparam int CW = $clog2(FQ_DEPTH) + 1;

    logic [15:0]   fpc;
    logic [15:0]   rpc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fq_count;
    logic          fq_empty;
    logic          fq_full;
    fq_entry_t     fq_head;
    fq_entry_t     fq_din;

    logic          issue;
    logic          resp_live;
    logic          resp_drop;
    logic          advance;
    logic          bypass;
    logic          fq_push;
    logic          fq_pop;

    // Issue is capped by words already queued plus words still in flight; held off during reset
    assign imem_req  = rst_n && !redirect && !fq_full
                       && ((int'(outstanding) + int'(fq_count)) < FQ_DEPTH);
    assign imem_addr = fpc;
    assign issue     = imem_req && imem_gnt;

    // Responses owed to a pre-redirect stream are discarded while drop_cnt is non-zero
    assign resp_live = imem_rvalid && (drop_cnt == '0) && !redirect;
    assign resp_drop = imem_rvalid && (drop_cnt != '0);
    assign advance   = !stall && !redirect;

`ifdef IF_BYPASS_EN
    assign bypass = resp_live && fq_empty && advance;
`else
    assign bypass = 1'b0;
`endif

    assign fq_push = resp_live && !bypass;
    assign fq_pop  = advance && !fq_empty;
    assign fq_din  = '{instr: imem_rdata, pc_inc: rpc + 16'd1};

    // Every response retires one request whether it is kept or dropped
    assign outstanding_next = outstanding + CW'(issue) - CW'(imem_rvalid);

    fetch_fifo #(
        .DEPTH (FQ_DEPTH)
    ) u_fetch_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fq_push),
        .din   (fq_din),
        .pop   (fq_pop),
        .flush (redirect),
        .dout  (fq_head),
        .count (fq_count),
        .empty (fq_empty),
        .full  (fq_full)
    );

    // Fetch/response PCs and in-flight accounting; redirect restarts both PCs and drops all in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc         <= RESET_PC;
            rpc         <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                fpc      <= redirect_pc;
                rpc      <= redirect_pc;
                drop_cnt <= outstanding_next;
            end else begin
                if (issue)     fpc      <= fpc + 16'd1;
                if (resp_live) rpc      <= rpc + 16'd1;
                if (resp_drop) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // IF/ID register: bubble on redirect, hold on stall, otherwise take the next available word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr    <= NOP_INSTR;
            PC_inc   <= 16'h0000;
            if_valid <= 1'b0;
        end else if (redirect) begin
            instr    <= NOP_INSTR;
            if_valid <= 1'b0;
        end else if (advance) begin
            if (bypass) begin
                instr    <= imem_rdata;
                PC_inc   <= rpc + 16'd1;
                if_valid <= 1'b1;
            end else if (!fq_empty) begin
                instr    <= fq_head.instr;
                PC_inc   <= fq_head.pc_inc;
                if_valid <= 1'b1;
            end else begin
                instr    <= NOP_INSTR;
                if_valid <= 1'b0;
            end
        end
    end

endmodule
